// File: rtl/alu_operand_loader_pkg.sv
// Shared definitions for the operand-loader front end of the 4-bit ALU / 7-seg path:
// stage encodings, ALU op codes and default widths.
package alu_operand_loader_pkg;

   localparam int unsigned DEF_WIDTH           = 4;
   localparam int unsigned DEF_OPW             = 3;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;

   // Capture stage; value is also what the board LEDs show.
   typedef enum logic [1:0] {
      S_A    = 2'd0,
      S_B    = 2'd1,
      S_OP   = 2'd2,
      S_SHOW = 2'd3
   } stage_e;

   // ALU op codes understood by the downstream ALU.
   typedef enum logic [2:0] {
      OP_ADD     = 3'b000,
      OP_SUB     = 3'b001,
      OP_NOT     = 3'b010,
      OP_AND     = 3'b011,
      OP_OR      = 3'b100,
      OP_XOR     = 3'b101,
      OP_NZ_DIFF = 3'b110,
      OP_EQ      = 3'b111
   } alu_op_e;

   // Stage that follows an accepted press in stage s.
   function automatic stage_e stage_after_press(input stage_e s);
      stage_e n;
      case (s)
         S_A:     n = S_B;
         S_B:     n = S_OP;
         S_OP:    n = S_SHOW;
         S_SHOW:  n = S_A;
         default: n = S_A;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/alu_operand_loader_btn_debounce.sv
// Push-button front end: 2-flop synchroniser, stability-counter debounce and
// a registered one-cycle pulse on every accepted 0->1 transition.
module btn_debounce
   import alu_operand_loader_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             sync1_q;
   logic             sync2_q;
   logic             filt_q;
   logic             filt_d;
   logic             filt_dly_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             press_q;
   logic             press_d;
   logic             btn_s;

   assign btn_s = sync2_q;

   // Debounce: count consecutive cycles of disagreement, flip the filtered level once it persists.
   always_comb begin
      filt_d  = filt_q;
      cnt_d   = '0;
      press_d = filt_q & ~filt_dly_q;
      if (btn_s == filt_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         filt_d = ~filt_q;
         cnt_d  = '0;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // Synchroniser, filter, edge-detect and pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         filt_q     <= 1'b0;
         cnt_q      <= '0;
         filt_dly_q <= 1'b0;
         press_q    <= 1'b0;
      end else begin
         sync1_q    <= btn_raw;
         sync2_q    <= sync1_q;
         filt_q     <= filt_d;
         cnt_q      <= cnt_d;
         filt_dly_q <= filt_q;
         press_q    <= press_d;
      end
   end

   assign level = filt_q;
   assign press = press_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Captures A, B and then the op from the switch bus, one field per debounced
// button press, and holds them in registers for the ALU. valid marks a
// complete command and is only high while the result is being shown.
module alu_operand_loader
   import alu_operand_loader_pkg::*;
#(
   parameter int unsigned WIDTH           = DEF_WIDTH,
   parameter int unsigned OPW             = DEF_OPW,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn,
   input  logic [WIDTH-1:0] sw,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [OPW-1:0]   op,
   output logic             valid,
   output logic [1:0]       stage
);

   logic             press_s;
   logic             unused_level_s;

   stage_e           stage_q;
   stage_e           stage_d;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] a_d;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] b_d;
   logic [OPW-1:0]   op_q;
   logic [OPW-1:0]   op_d;
   logic             valid_q;
   logic             valid_d;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn),
      .level   (unused_level_s),
      .press   (press_s)
   );

   // Next-state and capture: each press loads the field for the current stage and advances.
   always_comb begin
      stage_d = stage_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      valid_d = valid_q;
      if (press_s) begin
         stage_d = stage_after_press(stage_q);
         case (stage_q)
            S_A: begin
               a_d = sw;
            end
            S_B: begin
               b_d = sw;
            end
            S_OP: begin
               // op and valid change together so no half-formed command is ever visible.
               op_d    = sw[OPW-1:0];
               valid_d = 1'b1;
            end
            S_SHOW: begin
               valid_d = 1'b0;
            end
            default: begin
               stage_d = S_A;
               valid_d = 1'b0;
            end
         endcase
      end else begin
         stage_d = stage_q;
      end
   end

   // State and capture registers; reset discards any partial command.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_q <= S_A;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         stage_q <= stage_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         valid_q <= valid_d;
      end
   end

   assign a     = a_q;
   assign b     = b_q;
   assign op    = op_q;
   assign valid = valid_q;
   assign stage = stage_q;

endmodule
